// File: rtl/miriscv_rf_param_if.sv
// miriscv_rf_param_if -- bus bundle for the parameterised register file.
//
// Groups the read ports, both write ports, the clear request and the ready
// status. clk_i and reset_n are plain ports on the register file itself.
//   master : drives addresses, write controls and clear_i; observes data/ready
//   slave  : the register file side
interface miriscv_rf_param_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   raddr_i;
    logic [NRD*XLEN-1:0] rdata_o;
    logic                we_a_i;
    logic [AW-1:0]       wa_a_i;
    logic [XLEN-1:0]     wd_a_i;
    logic                we_b_i;
    logic [AW-1:0]       wa_b_i;
    logic [XLEN-1:0]     wd_b_i;
    logic                clear_i;
    logic                ready_o;

    modport master (
        output raddr_i, we_a_i, wa_a_i, wd_a_i, we_b_i, wa_b_i, wd_b_i, clear_i,
        input  rdata_o, ready_o
    );

    modport slave (
        input  raddr_i, we_a_i, wa_a_i, wd_a_i, we_b_i, wa_b_i, wd_b_i, clear_i,
        output rdata_o, ready_o
    );
endinterface

// File: rtl/miriscv_rf_param.sv
// miriscv_rf_param -- parameterised RISC-V style register file.
//
// NREGS x XLEN registers, NRD combinational read ports and two write ports
// (A has priority over B on an address collision). Register 0 reads as zero.
// After reset, or on a clear_i request, the file is zeroed by a sweep that
// writes one register per cycle (registers 1..NREGS-1); ready_o is high only
// once the sweep has finished, and reads return zero while it is low.
//
// Ports:
//   clk_i    : clock, all state changes on the rising edge
//   reset_n  : synchronous active-low reset
//   bus      : miriscv_rf_param_if.slave (raddr_i, rdata_o, we/wa/wd for A
//              and B, clear_i, ready_o)
//
// Configuration macro: RF_BYPASS_EN -- when defined, a read of an address
// being written in the same cycle returns the incoming write data (A over B);
// otherwise it returns the stored value until after the edge.
module miriscv_rf_param #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic                clk_i,
    input  logic                reset_n,
    miriscv_rf_param_if.slave   bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_ready;
    logic [XLEN-1:0] r_mem [NREGS];

    logic w_sweep_we;
    logic w_we_a;
    logic w_we_b;

    // Writes only land in READY on a non-reset edge that is not a clear edge.
    assign w_sweep_we = reset_n && (r_state == S_CLEAR);
    assign w_we_a     = reset_n && (r_state == S_READY) && !bus.clear_i &&
                        bus.we_a_i && (bus.wa_a_i != '0);
    assign w_we_b     = reset_n && (r_state == S_READY) && !bus.clear_i &&
                        bus.we_b_i && (bus.wa_b_i != '0);

    // Control FSM; ready_o is its own register so it cannot glitch.
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_state <= S_CLEAR;
            r_cnt   <= AW'(1);
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == AW'(NREGS - 1)) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                S_READY: begin
                    if (bus.clear_i) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= AW'(1);
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_cnt   <= AW'(1);
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage: no reset so the array maps onto RAM. Sweep and user writes are
    // mutually exclusive by state; B is written first so A wins a collision.
    always_ff @(posedge clk_i) begin
        if (w_sweep_we) begin
            r_mem[r_cnt] <= '0;
        end
        if (w_we_b) begin
            r_mem[bus.wa_b_i] <= bus.wd_b_i;
        end
        if (w_we_a) begin
            r_mem[bus.wa_a_i] <= bus.wd_a_i;
        end
    end

    assign bus.ready_o = r_ready;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;

        assign w_ra = bus.raddr_i[k*AW +: AW];

        always_comb begin
            w_rd = r_mem[w_ra];
`ifdef RF_BYPASS_EN
            if (w_we_b && (bus.wa_b_i == w_ra)) begin
                w_rd = bus.wd_b_i;
            end
            if (w_we_a && (bus.wa_a_i == w_ra)) begin
                w_rd = bus.wd_a_i;
            end
`endif
            // Address 0 and the not-ready state always read as zero.
            if (!r_ready || (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign bus.rdata_o[k*XLEN +: XLEN] = w_rd;
    end
endmodule

// File: tb/tb_miriscv_rf_param.sv
module tb_miriscv_rf_param;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk_i   = 1'b0;
    logic reset_n = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    miriscv_rf_param_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    miriscv_rf_param #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          we_a;
        logic [AW-1:0] wa_a;
        logic [31:0]   wd_a;
        logic          we_b;
        logic [AW-1:0] wa_b;
        logic [31:0]   wd_b;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [31:0]   exp0;
        logic [31:0]   exp1;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.we_a_i  = 1'b0;
        bus.wa_a_i  = '0;
        bus.wd_a_i  = '0;
        bus.we_b_i  = 1'b0;
        bus.wa_b_i  = '0;
        bus.wd_b_i  = '0;
        bus.clear_i = 1'b0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.raddr_i = {a1, a0};
        #1;
    endtask

    // Counts edges until ready_o rises; a bound of 100 edges guards against hangs.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (bus.ready_o) break;
        end
    endtask

    initial begin
        int n;
        idle();
        bus.raddr_i = '0;

        vecs[0]  = '{1'b1, 5'd1,  32'h1111_1111, 1'b1, 5'd2,  32'h2222_2222, 5'd3,  5'd4,  32'h0,          32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  32'h1111_1111, 32'h2222_2222};
        vecs[2]  = '{1'b1, 5'd5,  32'hAAAA_0001, 1'b1, 5'd5,  32'hBBBB_0002, 5'd1,  5'd0,  32'h1111_1111, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hAAAA_0001, 32'hAAAA_0001};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd31, 32'h3131_3131, 5'd2,  5'd5,  32'h2222_2222, 32'hAAAA_0001};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,          32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd31, 5'd1,  32'h3131_3131, 32'h1111_1111};
        vecs[7]  = '{1'b1, 5'd1,  32'h0,         1'b1, 5'd2,  32'h0000_0005, 5'd31, 5'd31, 32'h3131_3131, 32'h3131_3131};
        vecs[8]  = '{1'b0, 5'd6,  32'hDEAD_0000, 1'b1, 5'd6,  32'h0000_0066, 5'd1,  5'd2,  32'h0,          32'h0000_0005};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd6,  5'd0,  32'h0000_0066, 32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd1,  5'd31, 32'h0,          32'h3131_3131};

        // Reset held, then released with no other activity.
        tick();
        tick();
        set_ra(5'd3, 5'd0);
        chk("reset_ready", 32'(bus.ready_o), 32'h0);
        chk("reset_rd0", bus.rdata_o[31:0], 32'h0);
        reset_n = 1'b1;
        wait_ready(n);
        chk("reset_sweep_len", 32'(n), 32'd31);
        chk("post_reset_rd0", bus.rdata_o[31:0], 32'h0);
        chk("post_reset_rd1", bus.rdata_o[63:32], 32'h0);

        // Same-cycle write/read of address 7.
        set_ra(5'd7, 5'd0);
        bus.we_a_i = 1'b1;
        bus.wa_a_i = 5'd7;
        bus.wd_a_i = 32'h1234_5678;
        #1;
`ifdef RF_BYPASS_EN
        chk("bypass_same_cycle", bus.rdata_o[31:0], 32'h1234_5678);
`else
        chk("nobypass_same_cycle", bus.rdata_o[31:0], 32'h0);
`endif
        tick();
        idle();
        #1;
        chk("after_write_r7", bus.rdata_o[31:0], 32'h1234_5678);

        // Table-driven READY-state vectors; reads are checked before the edge.
        for (int i = 0; i < 11; i++) begin
            bus.we_a_i  = vecs[i].we_a;
            bus.wa_a_i  = vecs[i].wa_a;
            bus.wd_a_i  = vecs[i].wd_a;
            bus.we_b_i  = vecs[i].we_b;
            bus.wa_b_i  = vecs[i].wa_b;
            bus.wd_b_i  = vecs[i].wd_b;
            set_ra(vecs[i].ra0, vecs[i].ra1);
            chk($sformatf("vec%0d_rd0", i), bus.rdata_o[31:0], vecs[i].exp0);
            chk($sformatf("vec%0d_rd1", i), bus.rdata_o[63:32], vecs[i].exp1);
            tick();
        end
        idle();

        // clear_i with a simultaneous write: write dropped, full sweep follows.
        bus.clear_i = 1'b1;
        bus.we_a_i  = 1'b1;
        bus.wa_a_i  = 5'd3;
        bus.wd_a_i  = 32'hDEAD_BEEF;
        tick();
        idle();
        set_ra(5'd3, 5'd7);
        chk("clear_ready_low", 32'(bus.ready_o), 32'h0);
        chk("clear_rd_zero", bus.rdata_o[63:32], 32'h0);
        n = 0;
        while (n < 100) begin
            // clear_i mid-sweep must not restart it; writes mid-sweep must drop.
            bus.clear_i = (n == 5);
            bus.we_a_i  = (n == 20);
            bus.wa_a_i  = 5'd9;
            bus.wd_a_i  = 32'h9999_9999;
            tick();
            n++;
            if (bus.ready_o) break;
        end
        idle();
        chk("clear_sweep_len", 32'(n), 32'd31);
        set_ra(5'd3, 5'd7);
        chk("clear_r3", bus.rdata_o[31:0], 32'h0);
        chk("clear_r7", bus.rdata_o[63:32], 32'h0);
        set_ra(5'd9, 5'd31);
        chk("sweep_write_dropped_r9", bus.rdata_o[31:0], 32'h0);
        chk("clear_r31", bus.rdata_o[63:32], 32'h0);

        // Reset pulsed mid-sweep restarts the sweep after release.
        bus.we_a_i = 1'b1;
        bus.wa_a_i = 5'd4;
        bus.wd_a_i = 32'h0000_4444;
        tick();
        idle();
        set_ra(5'd4, 5'd0);
        chk("pre_clear_r4", bus.rdata_o[31:0], 32'h0000_4444);
        bus.clear_i = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 10; i++) tick();
        reset_n = 1'b0;
        bus.clear_i = 1'b1;
        tick();
        reset_n = 1'b1;
        bus.clear_i = 1'b0;
        chk("midsweep_reset_ready", 32'(bus.ready_o), 32'h0);
        wait_ready(n);
        chk("midsweep_reset_len", 32'(n), 32'd31);
        set_ra(5'd4, 5'd0);
        chk("midsweep_reset_r4", bus.rdata_o[31:0], 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
